// File: rtl/usb_keys_nkro_pkg.sv
// Shared definitions for the NKRO keyboard report decoder: FSM state
// encoding, the ErrorRollOver scan code and the default frame-sync pattern.
package usb_keys_pkg;

    typedef enum logic [2:0] {
        ST_LOOK = 3'd0,
        ST_MASK = 3'd1,
        ST_RES  = 3'd2,
        ST_CODE = 3'd3,
        ST_EVAL = 3'd4
    } state_t;

    localparam logic [7:0]  ERR_ROLLOVER  = 8'h01;
    localparam logic [23:0] DEFAULT_MAGIC = 24'h57AB01;

endpackage

// File: rtl/usb_keys_nkro_if.sv
// Byte-in / key-out stream bundle of the NKRO decoder. The master side
// feeds report bytes and consumes translated keys; the slave is the decoder.
interface usb_keys_nkro_if;

    logic [7:0] i_byte;
    logic       i_byte_valid;
    logic       o_byte_ready;
    logic [7:0] o_key;
    logic       o_key_valid;
    logic       i_key_ready;
    logic       o_overrun;

    modport master (
        output i_byte, i_byte_valid, i_key_ready,
        input  o_byte_ready, o_key, o_key_valid, o_overrun
    );

    modport slave (
        input  i_byte, i_byte_valid, i_key_ready,
        output o_byte_ready, o_key, o_key_valid, o_overrun
    );

endinterface

// File: rtl/usb_keys_nkro_keymap.sv
// Combinational HID scan code + modifier to ASCII translation. Either shift
// modifier (left bit 1, right bit 5) selects upper case / shifted digits.
// Codes without a printable mapping translate to 0 and are never emitted.
module hid_keymap (
    input  logic [7:0] i_code,
    input  logic [7:0] i_mod,
    output logic [7:0] o_ascii
);

    logic w_shift;

    assign w_shift = i_mod[1] | i_mod[5];

    // Letter range is arithmetic; digit row and specials are a lookup.
    always_comb begin
        o_ascii = 8'h00;
        if (i_code >= 8'h04 && i_code <= 8'h1D) begin
            o_ascii = (w_shift ? 8'h41 : 8'h61) + (i_code - 8'h04);
        end else begin
            case (i_code)
                8'h1E:   o_ascii = w_shift ? 8'h21 : 8'h31;
                8'h1F:   o_ascii = w_shift ? 8'h40 : 8'h32;
                8'h20:   o_ascii = w_shift ? 8'h23 : 8'h33;
                8'h21:   o_ascii = w_shift ? 8'h24 : 8'h34;
                8'h22:   o_ascii = w_shift ? 8'h25 : 8'h35;
                8'h23:   o_ascii = w_shift ? 8'h5E : 8'h36;
                8'h24:   o_ascii = w_shift ? 8'h26 : 8'h37;
                8'h25:   o_ascii = w_shift ? 8'h2A : 8'h38;
                8'h26:   o_ascii = w_shift ? 8'h28 : 8'h39;
                8'h27:   o_ascii = w_shift ? 8'h29 : 8'h30;
                8'h28:   o_ascii = 8'h0D;
                8'h2C:   o_ascii = 8'h20;
                default: o_ascii = 8'h00;
            endcase
        end
    end

endmodule

// File: rtl/usb_keys_nkro.sv
// NKRO keyboard report decoder: finds sync, latches modifier and scan codes,
// then walks the slots one per cycle pushing newly pressed keys (translated
// to ASCII) into an output FIFO. Keys already held in the previous report
// are suppressed; ErrorRollOver reports are dropped without touching history.
module usb_keys_nkro
    import usb_keys_pkg::*;
#(
    parameter int                     MAGIC_LEN  = 3,
    parameter logic [MAGIC_LEN*8-1:0] MAGIC      = DEFAULT_MAGIC,
    parameter int                     RES_BYTES  = 1,
    parameter int                     NKEYS      = 6,
    parameter int                     FIFO_DEPTH = 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    usb_keys_nkro_if.slave  bus
);

    localparam int SYNC_W   = (MAGIC_LEN > 1) ? $clog2(MAGIC_LEN) : 1;
    localparam int RES_W    = (RES_BYTES > 1) ? $clog2(RES_BYTES) : 1;
    localparam int SLOT_W   = (NKEYS > 1) ? $clog2(NKEYS) : 1;
    localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int RES_LAST = (RES_BYTES > 0) ? RES_BYTES - 1 : 0;

    // Sync byte at position idx, MSB byte of MAGIC first.
    function automatic logic [7:0] sync_byte(input logic [SYNC_W-1:0] idx);
        return MAGIC[(MAGIC_LEN - 1 - int'(idx)) * 8 +: 8];
    endfunction

    state_t             r_state, w_next;
    logic [SYNC_W-1:0]  r_sync_idx;
    logic [RES_W-1:0]   r_res_cnt;
    logic [SLOT_W-1:0]  r_code_idx;
    logic [SLOT_W-1:0]  r_slot;
    logic [7:0]         r_mask;
    logic [7:0]         r_cur  [NKEYS];
    logic [7:0]         r_prev [NKEYS];

    logic [7:0]         r_mem  [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wptr, r_rptr;
    logic [PTR_W:0]     r_count;
    logic               r_overrun;

    logic               w_byte_ready, w_accept;
    logic               w_sync_hit, w_sync_last, w_res_last, w_code_last, w_slot_last;
    logic               w_err, w_held, w_qual;
    logic [7:0]         w_slot_code, w_xlat;
    logic               w_full, w_pop, w_push, w_space, w_eval_adv;

    assign w_accept    = bus.i_byte_valid && w_byte_ready;
    assign w_sync_hit  = (bus.i_byte == sync_byte(r_sync_idx));
    assign w_sync_last = (r_sync_idx == SYNC_W'(MAGIC_LEN - 1));
    assign w_res_last  = (r_res_cnt == RES_W'(RES_LAST));
    assign w_code_last = (r_code_idx == SLOT_W'(NKEYS - 1));
    assign w_slot_last = (r_slot == SLOT_W'(NKEYS - 1));
    assign w_slot_code = r_cur[r_slot];

    hid_keymap u_keymap (
        .i_code  (w_slot_code),
        .i_mod   (r_mask),
        .o_ascii (w_xlat)
    );

    // Report-wide ErrorRollOver flag and "current slot already held" lookup.
    always_comb begin
        w_err  = 1'b0;
        w_held = 1'b0;
        for (int i = 0; i < NKEYS; i++) begin
            if (r_cur[i] == ERR_ROLLOVER) w_err  = 1'b1;
            if (r_prev[i] == w_slot_code) w_held = 1'b1;
        end
    end

    // A full FIFO still accepts a push in the cycle the head is popped.
    assign w_full     = (r_count == (PTR_W + 1)'(FIFO_DEPTH));
    assign w_pop      = (r_count != '0) && bus.i_key_ready;
    assign w_space    = !w_full || w_pop;
    assign w_qual     = (w_slot_code != 8'h00) && !w_held && (w_xlat != 8'h00);
    assign w_eval_adv = (r_state == ST_EVAL) && !w_err && (!w_qual || w_space);
    assign w_push     = (r_state == ST_EVAL) && !w_err && w_qual && w_space;

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_LOOK;
        else          r_state <= w_next;
    end

    // FSM next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_LOOK: if (w_accept && w_sync_hit && w_sync_last) w_next = ST_MASK;
            ST_MASK: if (w_accept) w_next = (RES_BYTES == 0) ? ST_CODE : ST_RES;
            ST_RES:  if (w_accept && w_res_last) w_next = ST_CODE;
            ST_CODE: if (w_accept && w_code_last) w_next = ST_EVAL;
            ST_EVAL: if (w_err || (w_eval_adv && w_slot_last)) w_next = ST_LOOK;
            default: w_next = ST_LOOK;
        endcase
    end

    // FSM outputs: input is stalled only while slots are being evaluated.
    always_comb begin
        w_byte_ready = (r_state != ST_EVAL);
    end

    // Frame datapath: sync index, counters, modifier, current/previous slots.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync_idx <= '0;
            r_res_cnt  <= '0;
            r_code_idx <= '0;
            r_slot     <= '0;
            r_mask     <= '0;
            for (int i = 0; i < NKEYS; i++) begin
                r_cur[i]  <= '0;
                r_prev[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_LOOK: if (w_accept) begin
                    if (w_sync_hit)
                        r_sync_idx <= w_sync_last ? '0 : r_sync_idx + 1'b1;
                    else if (bus.i_byte == sync_byte('0))
                        r_sync_idx <= SYNC_W'(1);
                    else
                        r_sync_idx <= '0;
                end
                ST_MASK: if (w_accept) begin
                    r_mask     <= bus.i_byte;
                    r_res_cnt  <= '0;
                    r_code_idx <= '0;
                end
                ST_RES: if (w_accept) r_res_cnt <= r_res_cnt + 1'b1;
                ST_CODE: if (w_accept) begin
                    r_cur[r_code_idx] <= bus.i_byte;
                    r_code_idx        <= r_code_idx + 1'b1;
                    r_slot            <= '0;
                end
                ST_EVAL: if (w_eval_adv) begin
                    r_slot <= r_slot + 1'b1;
                    if (w_slot_last) r_prev <= r_cur;
                end
                default: ;
            endcase
        end
    end

    // FIFO pointers, occupancy and sticky overrun flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (bus.i_byte_valid && !w_byte_ready) r_overrun <= 1'b1;
        end
    end

    // FIFO storage; contents are only observable while occupancy is nonzero.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= w_xlat;
    end

    assign bus.o_byte_ready = w_byte_ready;
    assign bus.o_key_valid  = (r_count != '0);
    assign bus.o_key        = (r_count != '0) ? r_mem[r_rptr] : 8'h00;
    assign bus.o_overrun    = r_overrun;

endmodule

// File: tb/tb_usb_keys_nkro.sv
// Self-checking bench for usb_keys_nkro: directed report scenarios plus a
// randomized frame stream scored against a report-level key model.
module tb_usb_keys_nkro;
    import usb_keys_pkg::*;

    localparam int NK = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    usb_keys_nkro_if bus();

    usb_keys_nkro #(
        .MAGIC_LEN  (3),
        .MAGIC      (24'h57AB01),
        .RES_BYTES  (1),
        .NKEYS      (NK),
        .FIFO_DEPTH (2)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_pop   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] m_prev[NK];
    bit         rdy_mode  = 1'b0;
    bit         rdy_fixed = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Expected ASCII of a scan code under a modifier byte.
    function automatic logic [7:0] xlat(input logic [7:0] c, input logic [7:0] m);
        string lo = "abcdefghijklmnopqrstuvwxyz";
        string up = "ABCDEFGHIJKLMNOPQRSTUVWXYZ";
        string dg = "1234567890";
        string sd = "!@#$%^&*()";
        bit sh = m[1] | m[5];
        if (c >= 8'h04 && c <= 8'h1D) return sh ? up.getc(int'(c) - 4) : lo.getc(int'(c) - 4);
        if (c >= 8'h1E && c <= 8'h27) return sh ? sd.getc(int'(c) - 30) : dg.getc(int'(c) - 30);
        if (c == 8'h28) return 8'h0D;
        if (c == 8'h2C) return 8'h20;
        return 8'h00;
    endfunction

    // Report-level model: new presses relative to the previous report.
    task automatic model_apply(input logic [7:0] m, input logic [8*NK-1:0] codes);
        logic [7:0] c [NK];
        bit err = 1'b0;
        for (int i = 0; i < NK; i++) begin
            c[i] = codes[8*(NK-1-i) +: 8];
            if (c[i] == 8'h01) err = 1'b1;
        end
        if (!err) begin
            for (int i = 0; i < NK; i++) begin
                bit held = 1'b0;
                for (int j = 0; j < NK; j++) if (m_prev[j] == c[i]) held = 1'b1;
                if (c[i] != 8'h00 && !held && xlat(c[i], m) != 8'h00) exp_q.push_back(xlat(c[i], m));
            end
            for (int i = 0; i < NK; i++) m_prev[i] = c[i];
        end
    endtask

    function automatic logic [31:0] pack_got();
        logic [31:0] v = '0;
        foreach (got_q[i]) v = {v[23:0], got_q[i]};
        return v;
    endfunction

    // Consumer and compare: every pop is scored against the model queue.
    always @(negedge clk) begin
        bus.i_key_ready = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_fixed;
        if (rst_n && bus.o_key_valid && bus.i_key_ready) begin
            n_pop++;
            got_q.push_back(bus.o_key);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious_key: got %0h, required none", bus.o_key);
            end else begin
                check("key_stream", {24'h0, bus.o_key}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        @(negedge clk);
        while (!bus.o_byte_ready && t < 1000) begin
            bus.i_byte_valid = 1'b0;
            @(negedge clk);
            t++;
        end
        if (t >= 1000) begin
            n_tests++;
            n_fail++;
            $display("FAIL byte_ready_timeout: got 0, required 1");
        end
        bus.i_byte       = b;
        bus.i_byte_valid = 1'b1;
        @(posedge clk);
        #1 bus.i_byte_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] m, input logic [8*NK-1:0] codes);
        send_byte(8'h57);
        send_byte(8'hAB);
        send_byte(8'h01);
        send_byte(m);
        send_byte(8'h00);
        for (int i = 0; i < NK; i++) send_byte(codes[8*(NK-1-i) +: 8]);
        model_apply(m, codes);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        got_q.delete();
        for (int i = 0; i < NK; i++) m_prev[i] = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int pops0;
        bus.i_byte       = 8'h00;
        bus.i_byte_valid = 1'b0;
        for (int i = 0; i < NK; i++) m_prev[i] = 8'h00;

        // Model pinned against hand-computed translations.
        check("model_xlat_a", {24'h0, xlat(8'h04, 8'h00)}, 32'h61);
        check("model_xlat_B", {24'h0, xlat(8'h05, 8'h20)}, 32'h42);
        check("model_xlat_0", {24'h0, xlat(8'h27, 8'h00)}, 32'h30);

        // Reset state.
        #2;
        check("rst_key_valid", {31'h0, bus.o_key_valid}, 32'h0);
        check("rst_key", {24'h0, bus.o_key}, 32'h0);
        check("rst_byte_ready", {31'h0, bus.o_byte_ready}, 32'h1);
        check("rst_overrun", {31'h0, bus.o_overrun}, 32'h0);

        // Single key, latency, then held / released / re-pressed.
        do_reset();
        rdy_mode = 1'b0; rdy_fixed = 1'b0;
        send_frame(8'h00, 48'h040000000000);
        check("lat_edgeN_valid", {31'h0, bus.o_key_valid}, 32'h0);
        wait_cyc(1);
        check("lat_edgeN1_valid", {31'h0, bus.o_key_valid}, 32'h1);
        check("lat_edgeN1_key", {24'h0, bus.o_key}, 32'h61);
        rdy_fixed = 1'b1;
        wait_cyc(4);
        check("one_pop_count", got_q.size(), 32'd1);
        check("one_pop_key", pack_got(), 32'h61);
        check("valid_after_pop", {31'h0, bus.o_key_valid}, 32'h0);
        send_frame(8'h00, 48'h040000000000);
        send_frame(8'h00, 48'h000000000000);
        send_frame(8'h00, 48'h040000000000);
        wait_cyc(10);
        check("repress_keys", pack_got(), 32'h6161);

        // Shifted keys, then only the new press from an extended report.
        do_reset();
        send_frame(8'h02, 48'h040500000000);
        send_frame(8'h02, 48'h040506000000);
        wait_cyc(10);
        check("shift_keys", pack_got(), 32'h414243);

        // ErrorRollOver report is dropped.
        do_reset();
        send_frame(8'h00, 48'h010101010101);
        wait_cyc(10);
        check("rollover_none", got_q.size(), 32'd0);
        send_frame(8'h00, 48'h040000000000);
        wait_cyc(10);
        check("after_rollover", pack_got(), 32'h61);

        // Backpressure: FIFO of two, three new keys.
        do_reset();
        rdy_fixed = 1'b0;
        check("pre_overrun", {31'h0, bus.o_overrun}, 32'h0);
        send_frame(8'h00, 48'h040506000000);
        wait_cyc(4);
        check("eval_hold_ready", {31'h0, bus.o_byte_ready}, 32'h0);
        @(negedge clk);
        bus.i_byte = 8'h55;
        bus.i_byte_valid = 1'b1;
        @(posedge clk);
        #1 bus.i_byte_valid = 1'b0;
        check("overrun_set", {31'h0, bus.o_overrun}, 32'h1);
        rdy_fixed = 1'b1;
        wait_cyc(10);
        check("bp_keys", pack_got(), 32'h616263);
        check("bp_ready_back", {31'h0, bus.o_byte_ready}, 32'h1);
        check("overrun_sticky", {31'h0, bus.o_overrun}, 32'h1);

        // Sync restart, then reset in the middle of CODE.
        do_reset();
        rdy_fixed = 1'b0;
        send_byte(8'h57);
        send_frame(8'h00, 48'h040000000000);
        wait_cyc(2);
        check("restart_valid", {31'h0, bus.o_key_valid}, 32'h1);
        check("restart_key", {24'h0, bus.o_key}, 32'h61);
        send_byte(8'h57); send_byte(8'hAB); send_byte(8'h01);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h05); send_byte(8'h07);
        pops0 = n_pop;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", {31'h0, bus.o_key_valid}, 32'h0);
        check("midrst_key", {24'h0, bus.o_key}, 32'h0);
        check("midrst_ready", {31'h0, bus.o_byte_ready}, 32'h1);
        check("midrst_overrun", {31'h0, bus.o_overrun}, 32'h0);
        exp_q.delete();
        for (int i = 0; i < NK; i++) m_prev[i] = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        rdy_fixed = 1'b1;
        wait_cyc(15);
        check("midrst_no_key", n_pop - pops0, 32'd0);

        // Randomized frame stream with random consumer backpressure.
        do_reset();
        rdy_mode = 1'b1;
        for (int f = 0; f < 200; f++) begin
            logic [8*NK-1:0] codes;
            logic [7:0] m;
            int g = $urandom_range(0, 3);
            for (int k = 0; k < g; k++) begin
                logic [7:0] gb = 8'($urandom_range(0, 255));
                if (gb == 8'h57) gb = 8'h58;
                send_byte(gb);
            end
            case ($urandom_range(0, 3))
                0: m = 8'h00;
                1: m = 8'h02;
                2: m = 8'h20;
                default: m = 8'($urandom_range(0, 255));
            endcase
            for (int i = 0; i < NK; i++) begin
                int r = $urandom_range(0, 19);
                logic [7:0] c;
                if (r < 6)       c = 8'h00;
                else if (r < 15) c = 8'($urandom_range(4, 9));
                else if (r < 18) c = 8'($urandom_range(2, 8'h30));
                else if (r < 19) c = 8'h60;
                else             c = ($urandom_range(0, 3) == 0) ? 8'h01 : 8'h04;
                codes[8*(NK-1-i) +: 8] = c;
            end
            send_frame(m, codes);
            if ($urandom_range(0, 3) == 0) wait_cyc($urandom_range(1, 4));
        end
        rdy_mode = 1'b0;
        rdy_fixed = 1'b1;
        wait_cyc(30);
        check("rand_drained", exp_q.size(), 32'd0);
        check("rand_empty", {31'h0, bus.o_key_valid}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: got running, required finished");
        $fatal(1, "timeout");
    end

endmodule
